brianhg_display_rmem_ml: RTL
============================

// Module: brianhg_display_rmem_ml
// PURPOSE
//  Multi-layer DDR3 display raster read-address generator; successor to the single-layer generator.
//  On each video H-sync it computes per-layer line addresses and issues word reads to one DDR3 read port.
//  Each read tags the line-buffer slot (layer, line, word) via the vector field. Sits between video timing and DDR3_PHY_SEQ read channel.
//  Adds LAYERS channels, LB_LINES-deep line rotation, per-layer enable, Y clipping and sticky underrun flags.
// PARAMETERS
//  PORT_ADDR_SIZE    24   byte address width of DDR3 port
//  PORT_VECTOR_SIZE  12   vector width; >= LYR_W+LIN_W+WRD_W, elaboration $error otherwise
//  PORT_R_DATA_WIDTH 128  read word bits; WORD_B=PORT_R_DATA_WIDTH/8 bytes, WSH=$clog2(WORD_B)
//  LAYERS            2    layer count, 1..4; LYR_W=max(1,$clog2(LAYERS))
//  LB_LINES          2    line slots per layer, power of 2 >=2; LIN_W=$clog2(LB_LINES)
//  LB_WORDS          256  words per slot, power of 2; WRD_W=$clog2(LB_WORDS)
// PORTS  (per-layer buses are [LAYERS-1:0] unpacked arrays)
//  CMD_CLK            in   1      sole clock
//  reset              in   1      async, active-high
//  DISP_enable        in   [L]x1  layer enable
//  DISP_pixel_bytes   in   [L]x3  1/2/4 bytes per pixel; other values treated as 1
//  DISP_mem_addr      in   [L]x32 byte base of bitmap pixel 0,0
//  DISP_bitmap_width  in   [L]x16 bitmap width, pixels
//  DISP_xsize/ysize   in   [L]x14 output window, pixels/lines
//  DISP_xpos/ypos     in   [L]x14 window origin within bitmap
//  read_busy_in       in   1      DDR3 read port busy
//  read_req_out       out  1      one-cycle read request
//  read_adr_out       out  PORT_ADDR_SIZE  byte address, WORD_B aligned
//  read_line_mem_adr  out  PORT_VECTOR_SIZE  {zero pad, layer, line slot, word}
//  VID_xena_in        in   1      horizontal active
//  VID_yena_in        in   1      vertical active
//  VID_xpos_out       out  [L]xWSH  first-pixel byte offset in first word, latched at frame start
//  VID_ypos_out       out  [L]xLIN_W  slot the display should read now
//  underrun_out       out  [L]x1  sticky: line reads not finished before next H-sync
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rast_y=0, line slot counters=0.
//  hs = VID_xena_in & !registered VID_xena_in (rising edge); inputs sampled only in CALC.
//  FSM: IDLE -hs-> CALC -> ISSUE -> IDLE. hs in CALC/ISSUE: set underrun_out[k] for every enabled,
//   unfinished layer k (current + later), drop remaining reads, go to CALC same cycle.
//  Frame start (hs & !VID_yena_in): rast_y<=0; row_base[k]<=DISP_mem_addr+(width*ypos+xpos)<<shift,
//   VID_xpos_out[k]<=(xpos<<shift)%WORD_B, word-aligned down; no reads; FSM->IDLE.
//  Active line (hs & VID_yena_in): CALC is LAYERS cycles, layer k in cycle k:
//   word count = ceil(((xsize<<shift)+VID_xpos_out[k])/WORD_B), clamped to LB_WORDS;
//   skip layer if !DISP_enable[k] or rast_y>=ysize[k]; slot[k]++ mod LB_LINES; row_base[k]+=width<<shift.
//  VID_ypos_out[k] <= slot[k]-1 mod LB_LINES, updated in the CALC cycle of layer k.
//  ISSUE: layers served in order 0..LAYERS-1; each layer's full word count goes before the next layer.
//   A request may issue in any cycle where read_busy_in=0 (sampled that cycle);
//   read_req_out, read_adr_out and read_line_mem_adr are registered and valid together for exactly 1 cycle.
//   Back-to-back requests are allowed. After each request: addr+=WORD_B, word index+1.
//  rast_y increments once per active-line hs, saturating at 14'h3FFF. All address math is mod 2^PORT_ADDR_SIZE.
//  Multiply width*ypos is a registered pipeline stage; CALC start waits 1 extra cycle after hs for it.
//  underrun_out clears only on reset or on frame start.
// CONFIGURATION
//  BHG_RMEM_XWRAP_EN defined: a layer's read address wraps to its row start once it passes
//   row start + (bitmap_width<<shift) bytes; gives horizontally tiled/scrolling bitmaps.
//  Not defined: addresses increment linearly past row end; no wrap logic synthesized.
// TESTING
//  T1 L=1, 4B px, xsize=64, xpos=0, busy=0: 16 reqs back-to-back at base, base+16 ... base+240; word idx 0..15.
//  T2 xpos=1 (4B): VID_xpos_out=4 after frame start, 17 reqs per line; xpos=4: offset 0, 16 reqs, base+16.
//  T3 L=2, both enabled: layer 0 words first (vector layer field 0), then layer 1; line slots alternate 0,1 each line.
//  T4 read_busy_in toggled 1/0 every cycle: no req during busy, word count and addresses unchanged vs T1.
//  T5 hs pulses 10 cycles apart with 16-word lines: underrun_out[0]=1, reads restart on new line; next frame start clears it.
//  T6 XWRAP_EN, width=32, 4B, xpos=24, xsize=32: addresses run row+96..row+112, then wrap to row+0; no wrap without macro.
//  Also: reset asserted mid-ISSUE -> read_req_out=0 next edge, all outputs 0.

Source files
------------

// File: rtl/brianhg_display_rmem_ml.sv
// Multi-layer DDR3 raster read-address generator with line-slot rotation.
// Define BHG_RMEM_XWRAP_EN to wrap reads horizontally within each bitmap row.
module brianhg_display_rmem_ml #(
  parameter int PORT_ADDR_SIZE    = 24,
  parameter int PORT_VECTOR_SIZE  = 12,
  parameter int PORT_R_DATA_WIDTH = 128,
  parameter int LAYERS            = 2,
  parameter int LB_LINES          = 2,
  parameter int LB_WORDS          = 256
) (
  input  logic                            CMD_CLK,
  input  logic                            reset,
  input  logic                            DISP_enable       [LAYERS-1:0],
  input  logic [2:0]                      DISP_pixel_bytes  [LAYERS-1:0],
  input  logic [31:0]                     DISP_mem_addr     [LAYERS-1:0],
  input  logic [15:0]                     DISP_bitmap_width [LAYERS-1:0],
  input  logic [13:0]                     DISP_xsize        [LAYERS-1:0],
  input  logic [13:0]                     DISP_ysize        [LAYERS-1:0],
  input  logic [13:0]                     DISP_xpos         [LAYERS-1:0],
  input  logic [13:0]                     DISP_ypos         [LAYERS-1:0],
  input  logic                            read_busy_in,
  output logic                            read_req_out,
  output logic [PORT_ADDR_SIZE-1:0]       read_adr_out,
  output logic [PORT_VECTOR_SIZE-1:0]     read_line_mem_adr,
  input  logic                            VID_xena_in,
  input  logic                            VID_yena_in,
  output logic [$clog2(PORT_R_DATA_WIDTH/8)-1:0] VID_xpos_out [LAYERS-1:0],
  output logic [$clog2(LB_LINES)-1:0]     VID_ypos_out      [LAYERS-1:0],
  output logic                            underrun_out      [LAYERS-1:0]
);
  localparam int A     = PORT_ADDR_SIZE;
  localparam int VW    = PORT_VECTOR_SIZE;
  localparam int WB    = PORT_R_DATA_WIDTH / 8;
  localparam int WSH   = $clog2(WB);
  localparam int LYR_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int LIN_W = $clog2(LB_LINES);
  localparam int WRD_W = $clog2(LB_WORDS);
  localparam int CW    = WRD_W + 1;

  if (VW < LYR_W + LIN_W + WRD_W) begin : g_vec_chk
    $error("PORT_VECTOR_SIZE too small for layer/line/word fields");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CALC, S_ISSUE} state_t;
  state_t state_q, state_d;

  logic             xena_q, frame_q, ld_q;
  logic [13:0]      rast_y_q, line_y_q;
  logic [LYR_W-1:0] cidx_q, cur_q;
  logic [CW-1:0]    widx_q;
  logic [A-1:0]     addr_q;
  logic [LAYERS-1:0] pend_q;
  logic [29:0]      prod_q   [LAYERS-1:0];
  logic [A-1:0]     row_q    [LAYERS-1:0];
  logic [A-1:0]     lbase_q  [LAYERS-1:0];
  logic [LIN_W-1:0] slot_q   [LAYERS-1:0];
  logic [LIN_W-1:0] lslot_q  [LAYERS-1:0];
  logic [CW-1:0]    wcnt_q   [LAYERS-1:0];
`ifdef BHG_RMEM_XWRAP_EN
  logic [17:0]      rowb_q   [LAYERS-1:0];
  logic [17:0]      xal_q    [LAYERS-1:0];
  logic [17:0]      off_q, off_nx;
`endif

  function automatic logic [1:0] shf(input logic [2:0] pb);
    case (pb)
      3'd2:    return 2'd1;
      3'd4:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  logic              hs, ldone, last, can_issue;
  logic [1:0]        sh;
  logic [17:0]       rb;
  logic [WSH-1:0]    xoff;
  logic [16:0]       tot, wc_full;
  logic [CW-1:0]     wc;
  logic [A-1:0]      fs_addr;
  logic [VW-1:0]     vec;
  logic [LAYERS-1:0] lost;

  assign hs = VID_xena_in & ~xena_q;

  always_comb begin
    sh      = shf(DISP_pixel_bytes[cidx_q]);
    rb      = {2'b0, DISP_bitmap_width[cidx_q]} << sh;
    xoff    = WSH'({2'b0, DISP_xpos[cidx_q]} << sh);
    tot     = {1'b0, {2'b0, DISP_xsize[cidx_q]} << sh}
            + 17'(VID_xpos_out[cidx_q]);
    wc_full = (tot + 17'(WB - 1)) >> WSH;
    wc      = (wc_full > 17'(LB_WORDS)) ? CW'(LB_WORDS)
                                        : wc_full[CW-1:0];
    fs_addr = A'(DISP_mem_addr[cidx_q]
            + ((32'(prod_q[cidx_q]) + 32'(DISP_xpos[cidx_q])) << sh));
  end

  always_comb begin
    ldone     = !ld_q && (widx_q == wcnt_q[cur_q]);
    last      = (cur_q == LYR_W'(LAYERS - 1));
    can_issue = !ld_q && !ldone && !read_busy_in;
    vec       = (VW'(cur_q) << (LIN_W + WRD_W))
              | (VW'(lslot_q[cur_q]) << WRD_W)
              | VW'(widx_q[WRD_W-1:0]);
`ifdef BHG_RMEM_XWRAP_EN
    off_nx    = off_q + 18'(WB);
`endif
  end

  // Layers still owed reads when a new line arrives early
  always_comb begin
    lost = pend_q;
    for (int k = 0; k < LAYERS; k++)
      if (!frame_q && DISP_enable[k] && line_y_q < DISP_ysize[k] &&
          (state_q == S_MUL ||
           (state_q == S_CALC && LYR_W'(k) >= cidx_q)))
        lost[k] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (hs) state_d = S_MUL;
    else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_MUL:   state_d = S_CALC;
        S_CALC:
          if (cidx_q == LYR_W'(LAYERS - 1))
            state_d = frame_q ? S_IDLE : S_ISSUE;
        S_ISSUE: if (ldone && last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CMD_CLK or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CMD_CLK or posedge reset) begin
    if (reset) begin
      xena_q <= 1'b0; frame_q <= 1'b0; ld_q <= 1'b0;
      rast_y_q <= '0; line_y_q <= '0;
      cidx_q <= '0; cur_q <= '0; widx_q <= '0;
      addr_q <= '0; pend_q <= '0;
      read_req_out <= 1'b0; read_adr_out <= '0; read_line_mem_adr <= '0;
`ifdef BHG_RMEM_XWRAP_EN
      off_q <= '0;
`endif
      for (int k = 0; k < LAYERS; k++) begin
        prod_q[k] <= '0; row_q[k] <= '0; lbase_q[k] <= '0;
        slot_q[k] <= '0; lslot_q[k] <= '0; wcnt_q[k] <= '0;
        VID_xpos_out[k] <= '0; VID_ypos_out[k] <= '0;
        underrun_out[k] <= 1'b0;
`ifdef BHG_RMEM_XWRAP_EN
        rowb_q[k] <= '0; xal_q[k] <= '0;
`endif
      end
    end else begin
      xena_q       <= VID_xena_in;
      read_req_out <= 1'b0;
      if (hs) begin
        frame_q <= !VID_yena_in;
        cidx_q  <= '0;
        pend_q  <= '0;
        if (!VID_yena_in) begin
          rast_y_q <= '0;
          for (int k = 0; k < LAYERS; k++) underrun_out[k] <= 1'b0;
        end else begin
          line_y_q <= rast_y_q;
          if (rast_y_q != 14'h3FFF) rast_y_q <= rast_y_q + 14'd1;
          if (state_q != S_IDLE)
            for (int k = 0; k < LAYERS; k++)
              if (lost[k]) underrun_out[k] <= 1'b1;
        end
      end else begin
        unique case (state_q)
          S_MUL:
            for (int k = 0; k < LAYERS; k++)
              prod_q[k] <= 30'(DISP_bitmap_width[k]) * 30'(DISP_ypos[k]);
          S_CALC: begin
            cidx_q <= cidx_q + LYR_W'(1);
            if (frame_q) begin
              row_q[cidx_q]        <= fs_addr & ~A'(WB - 1);
              VID_xpos_out[cidx_q] <= xoff;
            end else begin
              VID_ypos_out[cidx_q] <= slot_q[cidx_q] - LIN_W'(1);
              wcnt_q[cidx_q]       <= '0;
              if (DISP_enable[cidx_q] && line_y_q < DISP_ysize[cidx_q]) begin
                wcnt_q[cidx_q]  <= wc;
                pend_q[cidx_q]  <= (wc != '0);
                lbase_q[cidx_q] <= row_q[cidx_q];
                lslot_q[cidx_q] <= slot_q[cidx_q];
                slot_q[cidx_q]  <= slot_q[cidx_q] + LIN_W'(1);
                row_q[cidx_q]   <= row_q[cidx_q] + A'(rb);
`ifdef BHG_RMEM_XWRAP_EN
                rowb_q[cidx_q]  <= rb;
                xal_q[cidx_q]   <= ({2'b0, DISP_xpos[cidx_q], 2'b0} >> (2 - sh))
                                   & ~18'(WB - 1);
`endif
              end
            end
            cur_q  <= '0;
            widx_q <= '0;
            ld_q   <= 1'b1;
          end
          S_ISSUE: begin
            if (ld_q) begin
              ld_q   <= 1'b0;
              addr_q <= lbase_q[cur_q];
`ifdef BHG_RMEM_XWRAP_EN
              off_q  <= xal_q[cur_q];
`endif
            end else if (ldone) begin
              if (!last) begin
                cur_q  <= cur_q + LYR_W'(1);
                widx_q <= '0;
                ld_q   <= 1'b1;
              end
            end else if (can_issue) begin
              read_req_out      <= 1'b1;
              read_adr_out      <= addr_q;
              read_line_mem_adr <= vec;
              widx_q            <= widx_q + CW'(1);
              if (widx_q + CW'(1) == wcnt_q[cur_q]) pend_q[cur_q] <= 1'b0;
`ifdef BHG_RMEM_XWRAP_EN
              if (off_nx >= rowb_q[cur_q]) begin
                off_q  <= off_nx - rowb_q[cur_q];
                addr_q <= addr_q + A'(WB) - A'(rowb_q[cur_q]);
              end else begin
                off_q  <= off_nx;
                addr_q <= addr_q + A'(WB);
              end
`else
              addr_q <= addr_q + A'(WB);
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
